// File: rtl/alu_issue_ctrl.sv
// Issue controller for the two-phase 16-bit ALU: instruction FIFO,
// write-back scoreboard and one issue decision per two-cycle slot.
module alu_issue_ctrl #(
    parameter int DEPTH    = 4,
    parameter int WB_SLOTS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_rs1,
    input  logic [3:0]               in_rs2,
    input  logic [3:0]               in_rd,
    input  logic [3:0]               in_func,
    input  logic [7:0]               in_addr,
    output logic                     slot,
    output logic                     iss_valid,
    output logic [3:0]               iss_rs1,
    output logic [3:0]               iss_rs2,
    output logic [3:0]               iss_rd,
    output logic [3:0]               iss_func,
    output logic [7:0]               iss_addr,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     err_func,
    output logic [15:0]              stall_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [3:0] func;
        logic [7:0] addr;
    } instr_t;

    typedef enum logic {
        PH_SLOT = 1'b0,
        PH_EXEC = 1'b1
    } phase_e;

    phase_e phase_q;
    phase_e phase_d;

    instr_t          mem [DEPTH];
    instr_t          head;
    instr_t          iss_q;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic [WB_SLOTS-1:0] sb_valid;
    logic [3:0]          sb_rd [WB_SLOTS];

    logic empty;
    logic push;
    logic pop;
    logic take;
    logic illegal;
    logic hazard;
    logic do_drop;
    logic do_stall;
    logic do_issue;

    // Phase sequencer: slot phase carries the issue decision
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= PH_SLOT;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        unique case (phase_q)
            PH_SLOT: phase_d = PH_EXEC;
            PH_EXEC: phase_d = PH_SLOT;
        endcase
    end

    always_comb begin
        slot = (phase_q == PH_SLOT);
    end

    assign empty      = (count == '0);
    assign in_ready   = (count < CW'(DEPTH)) && !flush;
    assign push       = in_valid && in_ready;
    assign head       = mem[rd_ptr];
    assign illegal    = (head.func >= 4'd12);
    assign fifo_count = count;

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < WB_SLOTS; i++) begin
            if (sb_valid[i] &&
                (sb_rd[i] == head.rs1 || sb_rd[i] == head.rs2)) begin
                hazard = 1'b1;
            end
        end
    end

    // Decision terms are mutually exclusive; drop outranks the hazard check
    assign take     = slot && !flush && !empty;
    assign do_drop  = take && illegal;
    assign do_stall = take && !illegal && hazard;
    assign do_issue = take && !illegal && !hazard;
    assign pop      = do_drop || do_issue;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{rs1: in_rs1, rs2: in_rs2, rd: in_rd,
                             func: in_func, addr: in_addr};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Scoreboard shifts once per slot; bubbles enter on every non-issue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_valid <= '0;
            for (int i = 0; i < WB_SLOTS; i++) begin
                sb_rd[i] <= '0;
            end
        end else if (flush) begin
            sb_valid <= '0;
        end else if (slot) begin
            for (int i = WB_SLOTS - 1; i >= 1; i--) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_rd[i]    <= sb_rd[i-1];
            end
            sb_valid[0] <= do_issue;
            sb_rd[0]    <= head.rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iss_valid <= 1'b0;
            iss_q     <= '0;
        end else if (flush) begin
            iss_valid <= 1'b0;
        end else if (slot) begin
            iss_valid <= do_issue;
            if (do_issue) begin
                iss_q <= head;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_func  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (do_drop) begin
                err_func <= 1'b1;
            end
            if (do_stall && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    assign iss_rs1  = iss_q.rs1;
    assign iss_rs2  = iss_q.rs2;
    assign iss_rd   = iss_q.rd;
    assign iss_func = iss_q.func;
    assign iss_addr = iss_q.addr;
    assign busy     = !empty || (|sb_valid) || iss_valid;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: vector table plus
// hand sequences, issued instructions checked against a scoreboard.
module tb_alu_issue_ctrl;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_rs1, in_rs2, in_rd, in_func;
    logic [7:0] in_addr;
    logic       slot;
    logic       iss_valid;
    logic [3:0] iss_rs1, iss_rs2, iss_rd, iss_func;
    logic [7:0] iss_addr;
    logic [2:0] fifo_count;
    logic       busy;
    logic       err_func;
    logic [15:0] stall_cnt;

    alu_issue_ctrl #(.DEPTH(DEPTH), .WB_SLOTS(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_func(in_func), .in_addr(in_addr),
        .slot(slot), .iss_valid(iss_valid),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
        .iss_func(iss_func), .iss_addr(iss_addr),
        .fifo_count(fifo_count), .busy(busy),
        .err_func(err_func), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] f;
        int          cyc;
    } obs_t;

    typedef struct {
        logic [3:0] rs1, rs2, rd, func;
        logic [7:0] addr;
        bit         exp_issue;
        int         exp_gap;
    } vec_t;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    obs_t        obs[$];
    logic [23:0] exp_q[$];
    int          iss_cyc[$];
    bit          full_seen = 0;
    bit          full_ready_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (!slot && iss_valid)
                obs.push_back('{f: {iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr},
                                cyc: cyc});
            if (fifo_count == 3'(DEPTH)) begin
                full_seen = 1;
                if (in_ready) full_ready_bad = 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                      name, act, act, expv, expv);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic push(input logic [3:0] rs1, input logic [3:0] rs2,
                        input logic [3:0] rd, input logic [3:0] func,
                        input logic [7:0] addr, input bit exp_iss,
                        output int acc);
        bit rdy;
        in_valid = 1'b1;
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_func = func; in_addr = addr;
        acc = -1;
        for (int k = 0; k < 200 && acc < 0; k++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) acc = cyc;
        end
        in_valid = 1'b0;
        if (acc < 0) timeout("push");
        else if (exp_iss) exp_q.push_back({rs1, rs2, rd, func, addr});
    endtask

    task automatic drain();
        bit done = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        if (!done) timeout("drain");
        @(posedge clk);
        #1;
    endtask

    task automatic align(input bit want);
        for (int k = 0; k < 4 && slot != want; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_issues();
        int n;
        obs_t o;
        logic [23:0] e;
        iss_cyc.delete();
        chk("issue_count", obs.size(), exp_q.size());
        n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            o = obs.pop_front();
            e = exp_q.pop_front();
            chk("issue_fields", int'(o.f), int'(e));
            iss_cyc.push_back(o.cyc);
        end
        obs.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_t tbl[5];
        int   acc;
        int   accs[6];
        int   s0;

        tbl[0] = '{4'd1,  4'd2,  4'd3,  4'd0,  8'h10, 1'b1, 0};
        tbl[1] = '{4'd4,  4'd5,  4'd6,  4'd7,  8'h20, 1'b1, 2};
        tbl[2] = '{4'd7,  4'd8,  4'd9,  4'd3,  8'h31, 1'b1, 2};
        tbl[3] = '{4'd10, 4'd11, 4'd12, 4'd1,  8'h42, 1'b1, 2};
        tbl[4] = '{4'd14, 4'd15, 4'd0,  4'd11, 8'hA4, 1'b1, 2};

        // reset with in_valid held high
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1;
        in_rs1 = 4'd1; in_rs2 = 4'd2; in_rd = 4'd3;
        in_func = 4'd0; in_addr = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_slot", slot, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err_func", err_func, 0);
        reset = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("slot_toggle", slot, (k % 2 == 0) ? 1 : 0);
        end
        @(posedge clk);
        #1;

        // back-to-back independent instructions from the vector table
        s0 = stall_cnt;
        foreach (tbl[i])
            push(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].func,
                 tbl[i].addr, tbl[i].exp_issue, acc);
        drain();
        check_issues();
        for (int i = 1; i < iss_cyc.size(); i++)
            chk("b2b_gap", iss_cyc[i] - iss_cyc[i-1], tbl[i].exp_gap);
        chk("b2b_stall_cnt", stall_cnt - s0, 0);

        // RAW hazard: SUB reads ADD's rd
        s0 = stall_cnt;
        push(4'd1, 4'd2, 4'd3, 4'd0, 8'h01, 1'b1, acc);
        push(4'd3, 4'd4, 4'd5, 4'd1, 8'h02, 1'b1, acc);
        drain();
        check_issues();
        if (iss_cyc.size() == 2)
            chk("raw_gap", iss_cyc[1] - iss_cyc[0], 6);
        chk("raw_stall_cnt", stall_cnt - s0, 2);

        // full FIFO with a chain of dependent instructions
        for (int i = 0; i < 6; i++) begin
            push(4'd1, 4'd1, 4'd1, 4'd2, 8'(8'h80 + i), 1'b1, acc);
            accs[i] = acc;
            if (i == 4) begin
                chk("full_count", fifo_count, DEPTH);
                chk("full_in_ready", in_ready, 0);
            end
        end
        drain();
        check_issues();
        for (int i = 1; i < iss_cyc.size(); i++)
            chk("chain_gap", iss_cyc[i] - iss_cyc[i-1], 6);
        if (iss_cyc.size() > 1)
            chk("full_accept_after_pop", accs[5], iss_cyc[1] + 1);
        chk("full_seen", full_seen, 1);
        chk("full_ready_never", full_ready_bad, 0);

        // illegal func dropped, next instruction issues one slot later
        chk("err_before", err_func, 0);
        align(1'b0);
        push(4'd0, 4'd0, 4'd0, 4'd12, 8'hCC, 1'b0, acc);
        s0 = acc;
        push(4'd8, 4'd9, 4'd2, 4'd0, 8'h22, 1'b1, acc);
        drain();
        check_issues();
        if (iss_cyc.size() == 1)
            chk("illegal_next_issue", iss_cyc[0], s0 + 3);
        chk("err_func_set", err_func, 1);

        // flush with three queued and one in flight
        align(1'b1);
        push(4'd1, 4'd2, 4'd7, 4'd4, 8'h70, 1'b1, acc);
        push(4'd7, 4'd0, 4'd8, 4'd0, 8'h71, 1'b0, acc);
        push(4'd7, 4'd1, 4'd9, 4'd0, 8'h72, 1'b0, acc);
        push(4'd7, 4'd2, 4'd10, 4'd0, 8'h73, 1'b0, acc);
        chk("pre_flush_count", fifo_count, 3);
        chk("pre_flush_iss_valid", iss_valid, 1);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_count", fifo_count, 0);
        chk("flush_iss_valid", iss_valid, 0);
        chk("flush_busy", busy, 0);
        chk("flush_keeps_err", err_func, 1);
        s0 = stall_cnt;
        push(4'd7, 4'd9, 4'd11, 4'd5, 8'hE5, 1'b1, acc);
        drain();
        check_issues();
        if (iss_cyc.size() == 2)
            chk("post_flush_latency", iss_cyc[1] - acc, 1);
        chk("post_flush_no_stall", stall_cnt - s0, 0);

        // asynchronous reset mid-operation
        push(4'd1, 4'd2, 4'd3, 4'd6, 8'h91, 1'b0, acc);
        push(4'd3, 4'd3, 4'd4, 4'd6, 8'h92, 1'b0, acc);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_count", fifo_count, 0);
        chk("arst_iss_valid", iss_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_err_func", err_func, 0);
        chk("arst_stall_cnt", stall_cnt, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        obs.delete();
        exp_q.delete();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Instruction issue controller placed in front of the four-stage pipelined 16-bit ALU. It buffers incoming register-to-register instructions in a small FIFO and issues at most one instruction per two-cycle issue slot, matching the ALU's two-phase stage cadence. A register scoreboard stalls any instruction whose source registers are still being written by an in-flight instruction. The block also drops and flags illegal function codes, and supports a synchronous flush.

## Interface
- DEPTH, 4: instruction FIFO entries (power of two, ≥2)
- WB_SLOTS, 2: issue slots from an instruction's issue until its result is readable from the register bank
- clk  in  1  clock
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  synchronous clear of FIFO, scoreboard and issue outputs
- in_valid  in  1  instruction offered
- in_ready  out  1  FIFO can accept; `count < DEPTH && !flush`
- in_rs1, in_rs2, in_rd, in_func  in  4 each  instruction fields
- in_addr  in  8  memory write-back address
- slot  out  1  high in cycles where phase = 0, i.e. the issue-decision cycle
- iss_valid  out  1  issued instruction present on iss_* fields
- iss_rs1, iss_rs2, iss_rd, iss_func  out  4 each  issued fields
- iss_addr  out  8  issued address
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy
- busy  out  1  FIFO non-empty, or any scoreboard entry valid, or iss_valid
- err_func  out  1  sticky; set when an illegal func is dropped
- stall_cnt  out  16  count of hazard-stalled slots, saturating

## Operation
- Phase register:
  - reset value 0; toggles every cycle.
  - An issue decision is taken at the rising edge that ends a cycle with slot = 1.
- FIFO:
  - Push when in_valid && in_ready.
  - Push and pop in the same edge are allowed; count is unchanged.
  - A full FIFO deasserts in_ready even if a pop occurs that edge.
- Scoreboard: shift register of WB_SLOTS entries {valid, rd}. It advances only at slot edges:
  - entry[0] ← the issued instruction, or a bubble;
  - entry[i] ← entry[i-1];
  - the last entry retires.
- Hazard: the head's in_rs1 or in_rs2 equals the rd of any valid scoreboard entry. All funcs write rd.
- Slot-edge decision, in priority order:
  1. FIFO empty → bubble; iss_valid ← 0.
  2. Head func ≥ 12 → pop and drop; err_func ← 1; bubble; iss_valid ← 0. The hazard check does not apply.
  3. Hazard → no pop; bubble; iss_valid ← 0; stall_cnt += 1, saturating at 0xFFFF.
  4. Otherwise → pop; iss_* ← head fields; iss_valid ← 1; entry[0] ← {1, rd}.
- On non-slot edges, iss_* and iss_valid hold their values. An issued instruction is therefore presented for exactly 2 cycles.
- flush (sampled every edge; overrides everything including a push):
  - FIFO and scoreboard are emptied; iss_valid ← 0.
  - Phase, err_func and stall_cnt are kept.
- Reset values:
  - phase 0, count 0, all scoreboard entries invalid;
  - iss_valid 0, iss_* fields 0, err_func 0, stall_cnt 0;
  - busy 0, in_ready 1, slot 1.
- Reset asserted mid-operation discards all queued and in-flight instructions immediately (asynchronous).

## Timing
- Earliest issue:
  - An instruction pushed at a slot edge sees an empty-FIFO decision at that edge; it issues at the next slot edge, 2 cycles later.
  - An instruction pushed at a non-slot edge issues at the following edge, 1 cycle later.
- Throughput: one instruction per 2 cycles with no hazards.
- Dependent instruction, with the producer issued at slot edge S:
  - the consumer issues no earlier than slot edge S + 2·(WB_SLOTS+1) cycles;
  - with WB_SLOTS = 2, that is S+6, after 2 stalled slots.
- fifo_count, busy and in_ready are combinational from registered state and flush.
- stall_cnt and err_func update at slot edges only.

## Test plan
- **Reset:** assert reset with in_valid held high.
  - Required: iss_valid=0, fifo_count=0, in_ready=1, stall_cnt=0, slot=1.
  - After release, slot toggles 1,0,1,…
- **Back-to-back independent:** push ADD(rs1=1, rs2=2, rd=3), then XOR(rs1=4, rs2=5, rd=6).
  - Required: issues 2 cycles apart; iss_func=0 then 7; stall_cnt stays 0.
- **RAW hazard:** push ADD(rd=3), then SUB(rs1=3, rs2=4, rd=5).
  - Required: SUB issues exactly 6 cycles after ADD; stall_cnt=2.
- **Full FIFO:** push 4 mutually dependent instructions (rd=1, rs1=1 each) with no pops yet.
  - Required: in_ready=0 at fifo_count=4.
  - A 5th in_valid is not accepted until the first pop.
- **Illegal func:** push func=12, then func=0 (rd=2).
  - Required: func 12 is never issued; err_func=1; the func=0 instruction issues at the next slot edge.
- **Flush:** with 3 queued and 1 in flight, assert flush for 1 cycle.
  - Required: fifo_count=0, iss_valid=0, busy=0 the next cycle.
  - A new instruction then issues with no hazard stall.
